ofdm_pilots_remove: RTL and testbench

// - RX counterpart of the TX pilot-insertion stage. Sits between the RX FFT and the QAM16/QPSK demapper.
// - Accepts 64 FFT-bin samples per OFDM symbol, in natural bin order 0..63.
// - Discards the DC bin, the null bins 27..37 and the pilot bins 7, 21, 43 and 57.
// - Forwards the 48 data subcarriers in arrival order over the same CYC/STB/WE/ACK handshake used across the PHY chain.

---
 rtl/ofdm_pilots_remove.sv | 257 +++++++++++++++++++++++++
 tb/tb_ofdm_pilots_remove.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_pilots_remove.sv
// ---------------------------------------------------------------------------
// ofdm_pilots_remove
//
// Purpose
//   RX-side pilot/null removal between the FFT and the demapper. Takes the 64
//   FFT bins of each OFDM symbol in natural order (0..63), drops the DC bin,
//   the null bins 27..37 and the pilot bins 7/21/43/57, and forwards the 48
//   data subcarriers in arrival order over the CYC/STB/WE/ACK handshake.
//   The output stage is an output register plus a one-entry skid so that
//   ACK_O is purely registered (no ACK_I -> ACK_O combinational path).
//
// Optional feature (macro PILOT_CPE_EN)
//   When defined, the four pilots of each symbol are summed with base polarity
//   (+7, -21, +43, +57) into 18-bit I/Q sums, published with a one-cycle
//   PILOT_VLD pulse the cycle after bin 57 is accepted. When undefined the
//   ports and the accumulator do not exist; the data path is identical.
//
// Ports
//   CLK_I        in   1    clock
//   RST_I        in   1    asynchronous active-high reset
//   DAT_I        in   DW   FFT bin sample, I = [DW-1:DW/2], Q = [DW/2-1:0]
//   CYC_I        in   1    symbol valid; falling mid-symbol aborts it
//   STB_I        in   1    sample strobe
//   WE_I         in   1    write qualifier
//   ACK_O        out  1    input accepted (registered)
//   DAT_O        out  DW   data-subcarrier sample
//   CYC_O        out  1    output symbol in progress
//   STB_O        out  1    output strobe
//   WE_O         out  1    copy of STB_O
//   ACK_I        in   1    downstream accept
//   dataCount    out  6    data index 0..47 of the sample on DAT_O
//   PILOT_I_SUM  out  18   (PILOT_CPE_EN) signed pilot I sum
//   PILOT_Q_SUM  out  18   (PILOT_CPE_EN) signed pilot Q sum
//   PILOT_VLD    out  1    (PILOT_CPE_EN) sums valid pulse
// ---------------------------------------------------------------------------
module ofdm_pilots_remove #(
  parameter int DW   = 32,
  parameter int NFFT = 64
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I,
  output logic [5:0]    dataCount
`ifdef PILOT_CPE_EN
  ,
  output logic [17:0]   PILOT_I_SUM,
  output logic [17:0]   PILOT_Q_SUM,
  output logic          PILOT_VLD
`endif
);

  localparam logic [5:0] LAST_BIN  = 6'(NFFT - 1);
  localparam logic [5:0] LAST_DATA = 6'd47;

  // Input side
  logic [5:0]    r_bin;
  logic [5:0]    r_didx;
  logic          r_ack;

  // Output register and skid entry; each sample carries its data index
  logic [DW-1:0] r_dat;
  logic [5:0]    r_cnt;
  logic          r_stb;
  logic          r_cyc;
  logic [DW-1:0] r_skid_dat;
  logic [5:0]    r_skid_idx;
  logic          r_skid_vld;

  logic          w_acc;
  logic          w_is_data;
  logic          w_push;
  logic          w_xfer;
  logic [5:0]    w_didx_next;
  logic [DW-1:0] w_dat_next;
  logic [5:0]    w_cnt_next;
  logic          w_stb_next;
  logic          w_cyc_next;
  logic [DW-1:0] w_skid_dat_next;
  logic [5:0]    w_skid_idx_next;
  logic          w_skid_vld_next;

  assign w_acc  = CYC_I & STB_I & WE_I & r_ack;
  assign w_xfer = r_stb & ACK_I;

  // Data subcarriers: 1..26 and 38..63, minus the pilot bins.
  assign w_is_data = ((r_bin >= 6'd1 && r_bin <= 6'd26) || (r_bin >= 6'd38)) &&
                     (r_bin != 6'd7)  && (r_bin != 6'd21) &&
                     (r_bin != 6'd43) && (r_bin != 6'd57);
  assign w_push    = w_acc & w_is_data;

  // Index the next accepted data bin will carry. An abort (CYC_I low) and
  // bin 0 both restart it, so it reads 0 whenever no symbol is pending.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_didx_next = r_didx;
    if (!CYC_I) begin
      w_didx_next = 6'd0;
    end else if (w_acc && r_bin == 6'd0) begin
      w_didx_next = 6'd0;
    end else if (w_push) begin
      w_didx_next = (r_didx == LAST_DATA) ? 6'd0 : r_didx + 6'd1;
    end
  end

  // Output register / skid steering.
  always_comb begin
    w_dat_next      = r_dat;
    w_cnt_next      = r_cnt;
    w_stb_next      = r_stb;
    w_skid_dat_next = r_skid_dat;
    w_skid_idx_next = r_skid_idx;
    w_skid_vld_next = r_skid_vld;

    if (!r_stb || w_xfer) begin
      // Output slot free this cycle: oldest sample (skid) goes first.
      if (r_skid_vld) begin
        w_dat_next = r_skid_dat;
        w_cnt_next = r_skid_idx;
        w_stb_next = 1'b1;
        if (w_push) begin
          w_skid_dat_next = DAT_I;
          w_skid_idx_next = r_didx;
        end else begin
          w_skid_vld_next = 1'b0;
        end
      end else if (w_push) begin
        w_dat_next = DAT_I;
        w_cnt_next = r_didx;
        w_stb_next = 1'b1;
      end else begin
        // Empty: dataCount shows the index of the next expected sample,
        // which is 0 after the last sample of a symbol or an abort.
        w_stb_next = 1'b0;
        w_cnt_next = w_didx_next;
      end
    end else if (w_push) begin
      w_skid_dat_next = DAT_I;
      w_skid_idx_next = r_didx;
      w_skid_vld_next = 1'b1;
    end

    // CYC_O rises with data sample 0 and falls once the output is empty
    // with no further samples of the symbol expected.
    if (w_stb_next) begin
      w_cyc_next = r_cyc | (w_cnt_next == 6'd0);
    end else begin
      w_cyc_next = r_cyc & (w_didx_next != 6'd0);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_bin      <= 6'd0;
      r_didx     <= 6'd0;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_cnt      <= 6'd0;
      r_stb      <= 1'b0;
      r_cyc      <= 1'b0;
      r_skid_dat <= '0;
      r_skid_idx <= 6'd0;
      r_skid_vld <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!CYC_I) begin
        r_bin <= 6'd0;
      end else if (w_acc) begin
        r_bin <= (r_bin == LAST_BIN) ? 6'd0 : r_bin + 6'd1;
      end
      r_didx     <= w_didx_next;
      r_ack      <= ~w_skid_vld_next;
      r_dat      <= w_dat_next;
      r_cnt      <= w_cnt_next;
      r_stb      <= w_stb_next;
      r_cyc      <= w_cyc_next;
      r_skid_dat <= w_skid_dat_next;
      r_skid_idx <= w_skid_idx_next;
      r_skid_vld <= w_skid_vld_next;
    end
  end

  assign ACK_O     = r_ack;
  assign DAT_O     = r_dat;
  assign CYC_O     = r_cyc;
  assign STB_O     = r_stb;
  assign WE_O      = r_stb;
  assign dataCount = r_cnt;

`ifdef PILOT_CPE_EN
  logic signed [17:0] r_acc_i;
  logic signed [17:0] r_acc_q;
  logic signed [17:0] r_sum_i;
  logic signed [17:0] r_sum_q;
  logic               r_vld;
  logic signed [17:0] w_pil_i;
  logic signed [17:0] w_pil_q;
  logic signed [17:0] w_term_i;
  logic signed [17:0] w_term_q;

  assign w_pil_i = 18'(signed'(DAT_I[DW-1:DW/2]));
  assign w_pil_q = 18'(signed'(DAT_I[DW/2-1:0]));

  // Base pilot polarity: bin 21 is inverted, the other three are not.
  always_comb begin
    w_term_i = '0;
    w_term_q = '0;
    if (r_bin == 6'd7 || r_bin == 6'd43 || r_bin == 6'd57) begin
      w_term_i = w_pil_i;
      w_term_q = w_pil_q;
    end else if (r_bin == 6'd21) begin
      w_term_i = -w_pil_i;
      w_term_q = -w_pil_q;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_sum_i <= '0;
      r_sum_q <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_vld <= w_acc && (r_bin == 6'd57);
      if (w_acc) begin
        if (r_bin == 6'd0) begin
          r_acc_i <= '0;
          r_acc_q <= '0;
        end else begin
          r_acc_i <= r_acc_i + w_term_i;
          r_acc_q <= r_acc_q + w_term_q;
        end
        if (r_bin == 6'd57) begin
          r_sum_i <= r_acc_i + w_term_i;
          r_sum_q <= r_acc_q + w_term_q;
        end
      end
    end
  end

  assign PILOT_I_SUM = r_sum_i;
  assign PILOT_Q_SUM = r_sum_q;
  assign PILOT_VLD   = r_vld;
`endif

endmodule

// File: tb/tb_ofdm_pilots_remove.sv
// ---------------------------------------------------------------------------
// tb_ofdm_pilots_remove
//
// Directed bench: ramp, backpressure, back-to-back symbols, aborts, reset
// with buffered samples and (with PILOT_CPE_EN) the pilot sums. Expected
// outputs come from a hand-written table of the 48 data bins.
// ---------------------------------------------------------------------------
module tb_ofdm_pilots_remove;

  localparam int DW = 32;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic [DW-1:0] DAT_I;
  logic          CYC_I;
  logic          STB_I;
  logic          WE_I;
  logic          ACK_O;
  logic [DW-1:0] DAT_O;
  logic          CYC_O;
  logic          STB_O;
  logic          WE_O;
  logic          ACK_I = 1'b1;
  logic [5:0]    dataCount;
`ifdef PILOT_CPE_EN
  logic [17:0]   PILOT_I_SUM;
  logic [17:0]   PILOT_Q_SUM;
  logic          PILOT_VLD;
`endif

  ofdm_pilots_remove #(.DW(DW), .NFFT(64)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .DAT_I     (DAT_I),
    .CYC_I     (CYC_I),
    .STB_I     (STB_I),
    .WE_I      (WE_I),
    .ACK_O     (ACK_O),
    .DAT_O     (DAT_O),
    .CYC_O     (CYC_O),
    .STB_O     (STB_O),
    .WE_O      (WE_O),
    .ACK_I     (ACK_I),
    .dataCount (dataCount)
`ifdef PILOT_CPE_EN
    ,
    .PILOT_I_SUM (PILOT_I_SUM),
    .PILOT_Q_SUM (PILOT_Q_SUM),
    .PILOT_VLD   (PILOT_VLD)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic [5:0]    idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bin2idx[64];
  int   cyc_n = 0;
  int   bp_lo = -1;
  int   bp_hi = -1;
  bit   ack_hold = 1'b0;
  bit   chk_lat = 1'b0;
  int   ack_low_cnt = 0;
  int   xfer_cnt = 0;
  int   vld_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream accept: a cycle window for backpressure plus a hold flag.
  always begin
    @(posedge CLK_I);
    #2;
    cyc_n++;
    ACK_I = !(ack_hold || (cyc_n >= bp_lo && cyc_n <= bp_hi));
  end

  // Output monitor: every transfer is compared with the expected queue.
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (!ACK_O) ack_low_cnt++;
`ifdef PILOT_CPE_EN
      if (PILOT_VLD) vld_cnt++;
`endif
      if (STB_O && ACK_I) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_dat", DAT_O, mon_e.dat);
          check("out_cnt", dataCount, mon_e.idx);
          check("out_cyc", CYC_O, 1);
          check("out_we", WE_O, 1);
        end
      end
    end
  end

  // Offer one bin and wait (bounded) until it is accepted.
  task automatic push(input int bin, input logic [DW-1:0] val);
    bit ok = 1'b0;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    DAT_I = val;
    if (bin2idx[bin] >= 0) exp_q.push_back('{dat: val, idx: 6'(bin2idx[bin])});
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge CLK_I);
      ok = ACK_O;
      @(posedge CLK_I);
      #1;
    end
    if (!ok) begin
      check("push_timeout", 0, 1);
    end else if (chk_lat && bin2idx[bin] >= 0) begin
      check("lat_stb", STB_O, 1);
      check("lat_dat", DAT_O, val);
    end
  endtask

  task automatic ramp(input int last_bin, input logic [15:0] q_tag);
    for (int b = 0; b <= last_bin; b++) push(b, {16'(b), (q_tag == 16'hFFFF) ? 16'(b) : q_tag});
  endtask

  task automatic stop_input();
    STB_I = 1'b0;
    WE_I  = 1'b0;
    CYC_I = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge CLK_I);
    @(posedge CLK_I);
    #1;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_cyc_idle"}, CYC_O, 0);
    check({tag, "_cnt_idle"}, dataCount, 0);
    check({tag, "_stb_idle"}, STB_O, 0);
  endtask

  // Leaves sample 24 held in the output register and 25 in the skid.
  task automatic fill_skid();
    for (int b = 0; b <= 24; b++) push(b, {16'(b), 16'(b)});
    ack_hold = 1'b1;
    push(25, {16'd25, 16'd25});
    stop_input();
    repeat (2) @(posedge CLK_I);
    #1;
  endtask

  int lo_tab[6] = '{1, 8, 22, 38, 44, 58};
  int hi_tab[6] = '{6, 20, 26, 42, 56, 63};
  int x0;
  int a0;

  initial begin
    for (int b = 0; b < 64; b++) bin2idx[b] = -1;
    begin
      int k = 0;
      for (int r = 0; r < 6; r++)
        for (int b = lo_tab[r]; b <= hi_tab[r]; b++) begin
          bin2idx[b] = k;
          k++;
        end
    end

    RST_I = 1'b1;
    DAT_I = '0;
    stop_input();
    #1;
    check("rst_ack", ACK_O, 0);
    check("rst_stb", STB_O, 0);
    check("rst_cyc", CYC_O, 0);
    check("rst_we", WE_O, 0);
    check("rst_dat", DAT_O, 0);
    check("rst_cnt", dataCount, 0);
`ifdef PILOT_CPE_EN
    check("rst_pvld", PILOT_VLD, 0);
    check("rst_psum_i", PILOT_I_SUM, 0);
`endif
    repeat (3) @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    check("ack_after_rst", ACK_O, 1);

    // Ramp with latency check
    chk_lat = 1'b1;
    x0 = xfer_cnt;
    ramp(63, 16'hFFFF);
    chk_lat = 1'b0;
    stop_input();
    drain("ramp");
    check("ramp_count", xfer_cnt - x0, 48);

    // Backpressure on cycles 10..14 of the ramp
    a0 = ack_low_cnt;
    x0 = xfer_cnt;
    bp_lo = cyc_n + 10;
    bp_hi = cyc_n + 14;
    ramp(63, 16'hFFFF);
    stop_input();
    drain("bp");
    bp_lo = -1;
    bp_hi = -1;
    check("bp_count", xfer_cnt - x0, 48);
    check("bp_ack_low", (ack_low_cnt - a0 >= 1) && (ack_low_cnt - a0 <= 6), 1);

    // Three symbols back-to-back
    x0 = xfer_cnt;
    for (int s = 0; s < 3; s++) ramp(63, 16'(16'h0A00 + s));
    stop_input();
    drain("b2b");
    check("b2b_count", xfer_cnt - x0, 144);

    // Abort after bin 30, then a full symbol restarting at index 0
    x0 = xfer_cnt;
    ramp(30, 16'hFFFF);
    stop_input();
    drain("abort");
    check("abort_count", xfer_cnt - x0, 24);
    x0 = xfer_cnt;
    chk_lat = 1'b1;
    ramp(63, 16'hFFFF);
    chk_lat = 1'b0;
    stop_input();
    drain("post_abort");
    check("post_abort_count", xfer_cnt - x0, 48);

    // Abort with output register and skid both occupied
    fill_skid();
    check("ab_buf_stb", STB_O, 1);
    check("ab_buf_cyc", CYC_O, 1);
    check("ab_buf_ack", ACK_O, 0);
    x0 = xfer_cnt;
    ack_hold = 1'b0;
    drain("ab_buf");
    check("ab_buf_count", xfer_cnt - x0, 2);

    // Reset with output register and skid both occupied
    fill_skid();
    check("pre_rst_stb", STB_O, 1);
    RST_I = 1'b1;
    #1;
    check("midrst_stb", STB_O, 0);
    check("midrst_cyc", CYC_O, 0);
    check("midrst_ack", ACK_O, 0);
    check("midrst_cnt", dataCount, 0);
    exp_q.delete();
    ack_hold = 1'b0;
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    check("midrst_ack_back", ACK_O, 1);
    x0 = xfer_cnt;
    repeat (4) @(posedge CLK_I);
    #1;
    check("midrst_no_leak", xfer_cnt - x0, 0);

`ifdef PILOT_CPE_EN
    // Pilot sums: I = 100, 200, 300, 400; Q = 10, -5, 30, 40
    vld_cnt = 0;
    for (int b = 0; b < 64; b++) begin
      logic [DW-1:0] v;
      case (b)
        7:       v = {16'd100, 16'd10};
        21:      v = {16'd200, 16'hFFFB};
        43:      v = {16'd300, 16'd30};
        57:      v = {16'd400, 16'd40};
        default: v = {16'(b), 16'(b)};
      endcase
      push(b, v);
      if (b == 57) begin
        check("pvld_pulse", PILOT_VLD, 1);
        check("psum_i", PILOT_I_SUM, 18'd600);
        check("psum_q", PILOT_Q_SUM, 18'd85);
      end
      if (b == 58) begin
        check("pvld_low", PILOT_VLD, 0);
        check("psum_i_held", PILOT_I_SUM, 18'd600);
      end
    end
    stop_input();
    drain("pilot");
    check("pvld_once", vld_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
